// File: rtl/oam_dma_if.sv
`default_nettype none
// ============================================================================
// Module      : oam_dma_if
// Description : CPU register port, DMA source read port and OAM write port of
//               the OAM DMA controller, bundled for connection to the core.
// Revision    : 1.0 - initial release
// ============================================================================
interface oam_dma_if;
    logic        cpu_sel;
    logic        cpu_wr;
    logic [7:0]  cpu_di;
    logic [7:0]  cpu_do;
    logic        dma_rd;
    logic [15:0] dma_addr;
    logic [7:0]  dma_data;
    logic        oam_wr;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_data;
    logic        dma_active;
    logic        cpu_block;

    // The DMA controller side
    modport master (
        input  cpu_sel, cpu_wr, cpu_di, dma_data,
        output cpu_do, dma_rd, dma_addr, oam_wr, oam_addr, oam_data,
               dma_active, cpu_block
    );

    // The surrounding core (CPU, memories, OAM)
    modport slave (
        output cpu_sel, cpu_wr, cpu_di, dma_data,
        input  cpu_do, dma_rd, dma_addr, oam_wr, oam_addr, oam_data,
               dma_active, cpu_block
    );
endinterface
`default_nettype wire

// File: rtl/oam_dma.sv
`default_nettype none
// ============================================================================
// Module      : oam_dma
// Description : Game Boy OAM DMA. A write to $FF46 copies 160 bytes from a
//               256-byte-aligned source page into OAM, one byte every CPB
//               clocks, after a CPB-clock startup delay.
// Revision    : 1.0 - initial release
// ============================================================================
module oam_dma #(
    parameter int CPB = 4
) (
    input  wire logic   clk,
    input  wire logic   reset,
    oam_dma_if.master   bus
);
    localparam logic [3:0] PH_LAST  = 4'(CPB - 1);
    localparam logic [3:0] PH_PRE   = 4'(CPB - 2);
    localparam logic [7:0] IDX_LAST = 8'd159;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2
    } state_t;

    state_t      state;
    logic [7:0]  src_reg;
    logic [7:0]  page_pending;
    logic [7:0]  page_latched;
    logic [7:0]  idx;
    logic [7:0]  oam_idx;
    logic [3:0]  phase;
    logic [3:0]  pend_cnt;     // startup / restart delay counter
    logic        pend;         // a new transfer start is waiting for its delay
    logic        wr_d;
    logic        oam_wr_q;

    logic        wr_lvl;
    logic        trigger;
    logic        pend_done;
    logic [7:0]  new_page;

    assign wr_lvl    = bus.cpu_sel && bus.cpu_wr;
    assign trigger   = wr_lvl && !wr_d;
    assign pend_done = pend && (pend_cnt == PH_LAST);
    // Echo RAM and $FE/$FF pages fold back onto work RAM $C0-$DF
    assign new_page  = (bus.cpu_di < 8'hE0) ? bus.cpu_di : (bus.cpu_di - 8'h20);

    assign bus.cpu_do     = src_reg;
    assign bus.dma_rd     = (state == XFER);
    assign bus.cpu_block  = (state == XFER);
    assign bus.dma_active = (state != IDLE);
    assign bus.dma_addr   = {page_latched, idx};
    assign bus.oam_wr     = oam_wr_q;
    assign bus.oam_addr   = oam_idx;
    // Source data arrives one clock after the address; pass it only on the strobe
    assign bus.oam_data   = oam_wr_q ? bus.dma_data : 8'h00;

    // Register decode, start/restart delay and byte-slot sequencing
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            src_reg      <= 8'h00;
            page_pending <= 8'h00;
            page_latched <= 8'h00;
            idx          <= 8'h00;
            oam_idx      <= 8'h00;
            phase        <= 4'd0;
            pend_cnt     <= 4'd0;
            pend         <= 1'b0;
            wr_d         <= 1'b0;
            oam_wr_q     <= 1'b0;
        end else begin
            wr_d     <= wr_lvl;
            oam_wr_q <= 1'b0;
            if (wr_lvl) begin
                src_reg <= bus.cpu_di;
            end

            // A fresh trigger (re)starts the delay with the new page
            if (trigger) begin
                pend         <= 1'b1;
                pend_cnt     <= 4'd0;
                page_pending <= new_page;
            end else if (pend) begin
                pend_cnt <= pend_cnt + 4'd1;
            end

            case (state)
                IDLE: begin
                    if (trigger) begin
                        state <= START;
                    end
                end
                START: begin
                    if (!trigger && pend_done) begin
                        state        <= XFER;
                        pend         <= 1'b0;
                        idx          <= 8'h00;
                        phase        <= 4'd0;
                        page_latched <= page_pending;
                    end
                end
                XFER: begin
                    if (!trigger && pend_done) begin
                        // Restart delay expired: abandon the old copy
                        pend         <= 1'b0;
                        idx          <= 8'h00;
                        phase        <= 4'd0;
                        page_latched <= page_pending;
                    end else if (phase == PH_LAST) begin
                        phase <= 4'd0;
                        if (idx == IDX_LAST) begin
                            // Finish any restart delay still running in START
                            state <= (pend || trigger) ? START : IDLE;
                        end else begin
                            idx <= idx + 8'd1;
                        end
                    end else begin
                        phase <= phase + 4'd1;
                        if (phase == PH_PRE) begin
                            oam_wr_q <= 1'b1;
                            oam_idx  <= idx;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule
`default_nettype wire
